// File: rtl/packet_admit_ctrl_pkg.sv
// Shared definitions for the packet admission path.
//   state_t      : packet-level state of the admission controller
//   PKT_*        : default payload width and matching EOP bit position in wdata
//   sat_inc()    : saturating increment for counters up to 64 bits wide
package packet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int unsigned PKT_DATA_WIDTH = 31;
    // EOP sits directly above the payload in the FIFO word.
    localparam int unsigned PKT_EOP_BIT    = PKT_DATA_WIDTH;

    // Increment v, clamping at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/packet_admit_ctrl_if.sv
// Ingress word stream plus FIFO write-side signals of the admission stage.
//   in_valid/in_sop/in_eop/in_data : word stream, no backpressure
//   afull/wrcnt                    : FIFO prog_full and write-side count
//   wen/wdata                      : FIFO write, wdata = {eop, data}
// slave is the controller side, master the producer/FIFO model side.
interface packet_admit_ctrl_if
    import packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = PKT_DATA_WIDTH,
    parameter int unsigned WR_DATA_COUNT_WIDTH = 5
);
    logic                           in_valid;
    logic                           in_sop;
    logic                           in_eop;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           afull;
    logic [WR_DATA_COUNT_WIDTH-1:0] wrcnt;
    logic                           wen;
    logic [DATA_WIDTH:0]            wdata;

    modport master (
        output in_valid, in_sop, in_eop, in_data, afull, wrcnt,
        input  wen, wdata
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data, afull, wrcnt,
        output wen, wdata
    );
endinterface

// File: rtl/packet_admit_ctrl_sat_counter.sv
// Saturating event counter, synchronous active-high reset.
//   clk, rst : clock / reset
//   i_inc    : count one event this cycle
//   o_cnt    : current count, sticks at all-ones
module sat_counter
    import packet_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= CNT_WIDTH'(sat_inc(64'(r_cnt), CNT_WIDTH));
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/packet_admit_ctrl.sv
// Packet admission stage in front of the packet FIFO (write-clock domain).
// Decides per packet at SOP whether it fits, truncates over-long packets,
// closes packets that lose their EOP, and only ever writes packets that end
// with EOP=1 into the FIFO.
//   clk, rst          : write clock, synchronous active-high reset
//   bus (slave)       : input word stream, FIFO afull/wrcnt, FIFO wen/wdata
//   o_pass_cnt        : packets admitted
//   o_drop_cnt        : packets rejected at SOP
//   o_trunc_cnt       : packets cut at MAX_PKT_WORDS
//   o_malformed_cnt   : SOP while a packet is open, plus orphan words
//   o_busy            : a packet is open or a word is still held
module packet_admit_ctrl
    import packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = PKT_DATA_WIDTH,
    parameter int unsigned FIFO_WRITE_DEPTH    = 32,
    parameter int unsigned WR_DATA_COUNT_WIDTH = 5,
    parameter int unsigned MAX_PKT_WORDS       = 16,
    parameter int unsigned MARGIN              = 2,
    parameter int unsigned CNT_WIDTH           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    packet_admit_ctrl_if.slave   bus,
    output logic [CNT_WIDTH-1:0] o_pass_cnt,
    output logic [CNT_WIDTH-1:0] o_drop_cnt,
    output logic [CNT_WIDTH-1:0] o_trunc_cnt,
    output logic [CNT_WIDTH-1:0] o_malformed_cnt,
    output logic                 o_busy
);
    localparam int unsigned HR_W    = WR_DATA_COUNT_WIDTH + 2;
    localparam int unsigned WC_W    = $clog2(MAX_PKT_WORDS + 1);
    localparam int unsigned EOP_BIT = DATA_WIDTH;

    state_t                r_state, w_state_nxt;
    logic                  r_hold_vld;
    logic                  r_hold_eop;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [WC_W-1:0]       r_word_cnt;
    logic                  r_wen;
    logic [DATA_WIDTH:0]   r_wdata;

    logic [HR_W-1:0]       w_headroom;
    logic [WC_W-1:0]       w_word_cnt_nxt;
    logic                  w_sop, w_admit, w_cont, w_accept, w_close, w_trunc;
    logic                  w_wr, w_wr_eop, w_orphan;

    // Widened so that the subtraction can never wrap for any wrcnt value.
    assign w_headroom = HR_W'(FIFO_WRITE_DEPTH) - HR_W'(bus.wrcnt);
    assign w_sop      = bus.in_valid & bus.in_sop;
    assign w_admit    = w_sop & ~bus.afull & (w_headroom >= HR_W'(MAX_PKT_WORDS + MARGIN));
    assign w_cont     = bus.in_valid & ~bus.in_sop & (r_state == PASS);
    assign w_accept   = w_admit | w_cont;
    // A new SOP arriving while a packet is open ends the open packet.
    assign w_close    = w_sop & (r_state == PASS);
    assign w_orphan   = bus.in_valid & ~bus.in_sop & (r_state == IDLE);

    assign w_word_cnt_nxt = w_admit ? WC_W'(1) : r_word_cnt + WC_W'(1);
    assign w_trunc        = w_accept & ~bus.in_eop & (w_word_cnt_nxt == WC_W'(MAX_PKT_WORDS));

    // The held word only leaves once we know whether it is the last one:
    // either it already carries EOP, a successor arrived, or the packet was
    // cut short by a new SOP (which forces EOP on it).
    assign w_wr     = r_hold_vld & (r_hold_eop | w_accept | w_close);
    assign w_wr_eop = r_hold_eop | w_close;

    always_comb begin
        w_state_nxt = r_state;
        if (w_sop) begin
            if (bus.in_eop)
                w_state_nxt = IDLE;
            else if (!w_admit || w_trunc)
                w_state_nxt = DROP;
            else
                w_state_nxt = PASS;
        end else if (bus.in_valid && r_state != IDLE) begin
            if (bus.in_eop)
                w_state_nxt = IDLE;
            else if (w_trunc)
                w_state_nxt = DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_vld  <= 1'b0;
            r_hold_eop  <= 1'b0;
            r_hold_data <= '0;
            r_word_cnt  <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wen   <= w_wr;
            if (w_wr) begin
                r_wdata[EOP_BIT]     <= w_wr_eop;
                r_wdata[EOP_BIT-1:0] <= r_hold_data;
            end
            if (w_accept) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= bus.in_data;
                r_hold_eop  <= bus.in_eop | w_trunc;
                r_word_cnt  <= w_word_cnt_nxt;
            end else if (w_wr) begin
                r_hold_vld  <= 1'b0;
            end
        end
    end

    assign bus.wen   = r_wen;
    assign bus.wdata = r_wdata;
    assign o_busy    = (r_state != IDLE) | r_hold_vld;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk(clk), .rst(rst), .i_inc(w_admit), .o_cnt(o_pass_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk(clk), .rst(rst), .i_inc(w_sop & ~w_admit), .o_cnt(o_drop_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_trunc_cnt (
        .clk(clk), .rst(rst), .i_inc(w_trunc), .o_cnt(o_trunc_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_malformed_cnt (
        .clk(clk), .rst(rst), .i_inc(w_close | w_orphan), .o_cnt(o_malformed_cnt));

endmodule

// File: tb/tb_packet_admit_ctrl.sv
// Scoreboard bench for packet_admit_ctrl: a packet-level model queues the
// expected FIFO words as stimulus is issued; a monitor pops and compares on
// every wen.
module tb_packet_admit_ctrl;
    import packet_pkg::*;

    localparam int DW = 31, DEPTH = 32, WCW = 5, MAXW = 16, MARG = 2, CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_admit_ctrl_if #(.DATA_WIDTH(DW), .WR_DATA_COUNT_WIDTH(WCW)) bus ();

    logic [CW-1:0] pass_cnt, drop_cnt, trunc_cnt, mal_cnt;
    logic          busy;

    packet_admit_ctrl #(
        .DATA_WIDTH(DW), .FIFO_WRITE_DEPTH(DEPTH), .WR_DATA_COUNT_WIDTH(WCW),
        .MAX_PKT_WORDS(MAXW), .MARGIN(MARG), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_pass_cnt(pass_cnt), .o_drop_cnt(drop_cnt), .o_trunc_cnt(trunc_cnt),
        .o_malformed_cnt(mal_cnt), .o_busy(busy)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    int wr_cyc[$];
    logic [DW:0] exp_q[$];

    // reference model: packet-level view
    int m_pass = 0, m_drop = 0, m_trunc = 0, m_mal = 0;
    int mode = 0;            // 0 no packet, 1 admitted packet open, 2 discarding
    int m_len = 0;
    bit m_have = 1'b0;
    logic [DW-1:0] m_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic close_pkt();
        exp_q.push_back({1'b1, m_last});
        m_have = 1'b0;
    endtask

    // A word is known to be non-final as soon as its successor shows up.
    task automatic add_word(input bit eop, input logic [DW-1:0] d);
        if (m_have) exp_q.push_back({1'b0, m_last});
        m_last = d;
        m_have = 1'b1;
        m_len++;
        if (eop) begin
            close_pkt();
            mode = 0;
        end else if (m_len == MAXW) begin
            close_pkt();
            m_trunc++;
            mode = 2;
        end
    endtask

    task automatic model_word(input bit sop, input bit eop, input logic [DW-1:0] d);
        if (sop) begin
            if (mode == 1) begin
                close_pkt();
                m_mal++;
            end
            if (!bus.afull && (DEPTH - int'(bus.wrcnt)) >= MAXW + MARG) begin
                m_pass++;
                m_len = 0;
                mode  = 1;
                add_word(eop, d);
            end else begin
                m_drop++;
                mode = eop ? 0 : 2;
            end
        end else if (mode == 0) begin
            m_mal++;
        end else if (mode == 1) begin
            add_word(eop, d);
        end else if (eop) begin
            mode = 0;
        end
    endtask

    task automatic drive(input bit v, input bit sop, input bit eop, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_data  = d;
        if (v) model_word(sop, eop, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_pass_cnt"},  pass_cnt,  m_pass);
        chk({tag, "_drop_cnt"},  drop_cnt,  m_drop);
        chk({tag, "_trunc_cnt"}, trunc_cnt, m_trunc);
        chk({tag, "_mal_cnt"},   mal_cnt,   m_mal);
    endtask

    task automatic drain(input string tag);
        idle(4);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // monitor
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.wen) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got wdata %0h, none expected", bus.wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wdata", bus.wdata, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a1, a2, a3;
        int n0;
        bit v, sop, eop;
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_data  = '0;   bus.afull  = 1'b0; bus.wrcnt  = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", bus.wen, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_busy", busy, 0);
        check_counters("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 3-word packet and latency of the EOP word
        a1 = 31'h1A1; a2 = 31'h1A2; a3 = 31'h1A3;
        drive(1, 1, 0, a1);
        drive(1, 0, 0, a2);
        drive(1, 0, 1, a3);
        @(negedge clk);
        chk("a2_at_t1", {bus.wen, bus.wdata}, {1'b1, 1'b0, a2});
        @(negedge clk);
        chk("a3_at_t2", {bus.wen, bus.wdata}, {1'b1, 1'b1, a3});
        @(posedge clk); #1;
        drain("pkt3");
        check_counters("pkt3");

        // headroom too small, then admission boundaries
        bus.wrcnt = 5'd20;
        drive(1, 1, 0, 31'h2B1); drive(1, 0, 0, 31'h2B2);
        drive(1, 0, 0, 31'h2B3); drive(1, 0, 1, 31'h2B4);
        bus.wrcnt = 5'd15;  drive(1, 1, 1, 31'h2C1);   // headroom 17: reject
        bus.wrcnt = 5'd14;  drive(1, 1, 1, 31'h2C2);   // headroom 18: admit
        bus.wrcnt = 5'd0; bus.afull = 1'b1; drive(1, 1, 1, 31'h2C3);
        bus.afull = 1'b0;
        drive(1, 1, 0, 31'h2D1); drive(1, 0, 1, 31'h2D2);
        drain("drop");
        check_counters("drop");

        // 20 words without EOP until the last: truncation at 16
        n0 = wr_cyc.size();
        for (int i = 0; i < 20; i++) drive(1, i == 0, i == 19, DW'(32'h300 + i));
        drain("trunc");
        chk("trunc_writes", wr_cyc.size() - n0, MAXW);
        chk("trunc_busy", busy, 0);
        check_counters("trunc");

        // missing EOP closed by the next SOP
        drive(1, 1, 0, 31'h4A1); drive(1, 0, 0, 31'h4A2);
        drive(1, 1, 0, 31'h4B1); drive(1, 0, 1, 31'h4B2);
        drain("malformed");
        check_counters("malformed");

        // orphan words in IDLE
        drive(1, 0, 0, 31'h4C1); drive(1, 0, 1, 31'h4C2);
        drain("orphan");
        check_counters("orphan");

        // back-to-back single-word packets
        n0 = wr_cyc.size();
        for (int i = 0; i < 5; i++) drive(1, 1, 1, DW'(32'h500 + i));
        drain("b2b");
        chk("b2b_writes", wr_cyc.size() - n0, 5);
        chk("b2b_no_gap", wr_cyc[wr_cyc.size()-1] - wr_cyc[n0], 4);
        check_counters("b2b");

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            bus.wrcnt = ($urandom_range(0, 3) == 0) ? WCW'($urandom_range(14, 31))
                                                    : WCW'($urandom_range(0, 13));
            bus.afull = ($urandom_range(0, 9) == 0);
            v   = ($urandom_range(0, 9) < 7);
            sop = ($urandom_range(0, 3) == 0);
            eop = ($urandom_range(0, 3) == 0);
            drive(v, sop, eop, DW'($urandom));
        end
        bus.wrcnt = '0; bus.afull = 1'b0;
        drive(1, 1, 1, 31'h600);
        drain("rand");
        check_counters("rand");

        // reset while a packet is open with a held word
        drive(1, 1, 0, 31'h7A1);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        mode = 0; m_have = 1'b0; m_len = 0;
        m_pass = 0; m_drop = 0; m_trunc = 0; m_mal = 0;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_wen", bus.wen, 0);
        chk("post_rst_busy", busy, 0);
        check_counters("post_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        chk("post_rst_no_write", bus.wen, 0);
        check_counters("post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // default-width EOP position must match the wdata layout used above
    initial if (PKT_EOP_BIT != DW) $display("note: package EOP bit differs from bench width");

endmodule
